// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS main control unit.
package mips_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned SEL_W   = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_EXEC      = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [SEL_W-1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] SRC_B_REG     = 2'b00;
  localparam logic [SEL_W-1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [SEL_W-1:0] SRC_B_IMM     = 2'b10;
  localparam logic [SEL_W-1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_op;
    logic [SEL_W-1:0] pc_source;
  } ctrl_word_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state-to-control-word decoder; PC/IR writes in FETCH follow mem_ready.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output ctrl_word_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.alu_src_b = SRC_B_FOUR;
      end
      S_DECODE:  ctrl.alu_src_b = SRC_B_IMM_SH2;
      S_MEM_ADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
      default:   ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM: sequencing, opcode latch, retired-instruction counter.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [OP_W-1:0]        opcode,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   mem_to_reg,
  output logic                   reg_dst,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [SEL_W-1:0]       alu_src_b,
  output logic [SEL_W-1:0]       alu_op,
  output logic [SEL_W-1:0]       pc_source,
  output logic [STATE_W-1:0]     state,
  output logic                   illegal_op,
  output logic [INSTR_CNT_W-1:0] instr_count
);

  state_t                 state_q;
  state_t                 state_d;
  logic [OP_W-1:0]        op_q;
  logic [INSTR_CNT_W-1:0] cnt_q;
  logic                   retire;
  ctrl_word_t             ctrl;

  // State register, opcode latch (captured in DECODE) and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (retire) cnt_q <= cnt_q + INSTR_CNT_W'(1);
    end
  end

  always_comb begin
    state_d = S_FETCH;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = S_MEM_ADR;
        else if (opcode == OP_RTYPE)                state_d = S_EXEC;
        else if (opcode == OP_BEQ)                  state_d = S_BRANCH;
        else if (opcode == OP_J)                    state_d = S_JUMP;
        else if (opcode == OP_ADDI)                 state_d = S_ADDI_EXEC;
        else                                        state_d = S_FETCH;
      end
      S_MEM_ADR:   state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR: begin
        state_d = mem_ready ? S_FETCH : S_MEM_WR;
        retire  = mem_ready;
      end
      S_EXEC:      state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:     state_d = S_FETCH;
    endcase
  end

  mips_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Every output is held at zero while reset is asserted.
  always_comb begin
    pc_write      = rst_n & ctrl.pc_write;
    pc_write_cond = rst_n & ctrl.pc_write_cond;
    i_or_d        = rst_n & ctrl.i_or_d;
    mem_read      = rst_n & ctrl.mem_read;
    mem_write     = rst_n & ctrl.mem_write;
    ir_write      = rst_n & ctrl.ir_write;
    mem_to_reg    = rst_n & ctrl.mem_to_reg;
    reg_dst       = rst_n & ctrl.reg_dst;
    reg_write     = rst_n & ctrl.reg_write;
    alu_src_a     = rst_n & ctrl.alu_src_a;
    alu_src_b     = rst_n ? ctrl.alu_src_b : '0;
    alu_op        = rst_n ? ctrl.alu_op : '0;
    pc_source     = rst_n ? ctrl.pc_source : '0;
    state         = rst_n ? STATE_W'(state_q) : '0;
    illegal_op    = rst_n & (state_q == S_DECODE) & ~is_legal_op(opcode);
    instr_count   = rst_n ? cnt_q : '0;
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench: driver pushes per-cycle expectations from an instruction-level model; monitor compares.
module tb_mips_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] instr_count;

  mips_multicycle_control #(.INSTR_CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Spec state numbers
  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, EX = 6, RWB = 7;
  localparam int BR = 8, JP = 9, AE = 10, AWB = 11;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic [31:0] cnt;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    model_cnt = 0;
  bit    drv_done = 0;

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  // Control lines straight from the per-state table; packed as
  // {pc_write,pc_write_cond,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,reg_dst,reg_write,alu_src_a,src_b,alu_op,pc_src,illegal}
  function automatic logic [16:0] exp_ctrl(input int st, input bit rdy, input bit ill);
    bit pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0;
    bit [1:0] sb_ = 0, aop = 0, ps = 0;
    case (st)
      F:   begin mr = 1; irw = rdy; pw = rdy; sb_ = 2'd1; end
      D:   sb_ = 2'd3;
      MA:  begin sa = 1; sb_ = 2'd2; end
      MR:  begin mr = 1; iod = 1; end
      MWB: begin rw = 1; m2r = 1; end
      MW:  begin mw = 1; iod = 1; end
      EX:  begin sa = 1; aop = 2'd2; end
      RWB: begin rw = 1; rd = 1; end
      BR:  begin sa = 1; aop = 2'd1; pwc = 1; ps = 2'd1; end
      JP:  begin pw = 1; ps = 2'd2; end
      AE:  begin sa = 1; sb_ = 2'd2; end
      AWB: rw = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb_, aop, ps, ill};
  endfunction

  function automatic logic [5:0] rand_op();
    return 6'($urandom_range(0, 63));
  endfunction

  // One clock cycle of stimulus plus its expected response.
  task automatic step(input int st, input bit rdy, input bit rst, input logic [5:0] op);
    exp_t e;
    @(posedge clk); #1;
    rst_n = ~rst; mem_ready = rdy; opcode = op;
    if (rst) begin
      model_cnt = 0;
      e = '0;
    end else begin
      e.st   = 4'(st);
      e.ctrl = exp_ctrl(st, rdy, (st == D) && !legal(op));
      e.cnt  = 32'(model_cnt);
    end
    sb.push_back(e);
  endtask

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction-level model: state path and stalls per instruction class.
  task automatic run_instr(input logic [5:0] op, input int fs, input int ms, input bit rst_mid);
    for (int i = 0; i < fs; i++) step(F, 0, 0, rand_op());
    step(F, 1, 0, rand_op());
    step(D, rbit(), 0, op);
    case (op)
      6'b100011: begin
        step(MA, rbit(), 0, rand_op());
        for (int i = 0; i < ms; i++) step(MR, 0, 0, rand_op());
        if (rst_mid) begin
          step(F, rbit(), 1, rand_op());
          return;
        end
        step(MR, 1, 0, rand_op());
        step(MWB, rbit(), 0, rand_op());
        model_cnt++;
      end
      6'b101011: begin
        step(MA, rbit(), 0, rand_op());
        for (int i = 0; i < ms; i++) step(MW, 0, 0, rand_op());
        step(MW, 1, 0, rand_op());
        model_cnt++;
      end
      6'b000000: begin
        step(EX, rbit(), 0, rand_op());
        step(RWB, rbit(), 0, rand_op());
        model_cnt++;
      end
      6'b001000: begin
        step(AE, rbit(), 0, rand_op());
        step(AWB, rbit(), 0, rand_op());
        model_cnt++;
      end
      6'b000100: begin step(BR, rbit(), 0, rand_op()); model_cnt++; end
      6'b000010: begin step(JP, rbit(), 0, rand_op()); model_cnt++; end
      default: ;
    endcase
  endtask

  // Driver
  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
    ops[3] = 6'b001000; ops[4] = 6'b000100; ops[5] = 6'b000010;
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b0;
    step(F, 1, 1, 6'b0);
    step(F, 1, 1, 6'b0);
    run_instr(6'b100011, 0, 0, 0);
    run_instr(6'b000000, 0, 0, 0);
    run_instr(6'b000100, 0, 0, 0);
    run_instr(6'b000010, 0, 0, 0);
    run_instr(6'b101011, 2, 3, 0);
    run_instr(6'b111111, 0, 0, 0);
    run_instr(6'b001000, 1, 0, 0);
    run_instr(6'b100011, 0, 2, 1);
    run_instr(6'b100011, 0, 1, 0);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = rand_op(); while (legal(op));
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2),
                (op == 6'b100011) && ($urandom_range(0, 19) == 0));
    end
    @(posedge clk);
    drv_done = 1;
  end

  // Monitor: pops and compares once per cycle, away from the rising edge.
  initial begin
    exp_t e;
    logic [16:0] act;
    int cyc = 0;
    while (!(drv_done && sb.size() == 0)) begin
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin
        errors++;
        $display("FAIL timeout: scoreboard not drained, %0d entries left", sb.size());
        break;
      end
      if (sb.size() != 0) begin
        e   = sb.pop_front();
        act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
        checks++;
        if (state !== e.st) begin
          errors++;
          $display("FAIL state @%0t: got %0d want %0d", $time, state, e.st);
        end
        checks++;
        if (act !== e.ctrl) begin
          errors++;
          $display("FAIL ctrl @%0t state %0d: got %b want %b", $time, e.st, act, e.ctrl);
        end
        checks++;
        if (instr_count !== e.cnt) begin
          errors++;
          $display("FAIL instr_count @%0t: got %0d want %0d", $time, instr_count, e.cnt);
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
